// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cam_pkg
//  Purpose  : Shared constants for the colour-matrix consumer: Q16.16 unit
//             values, the identity matrix in flattened row-major form and the
//             element index of each matrix entry within the flat vector.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cam_pkg;

  localparam logic [31:0] Q_ONE  = 32'h0001_0000;
  localparam logic [31:0] Q_HALF = 32'h0000_8000;

  // Element i of the flat vector lives at bits [i*32 +: 32].
  localparam int M00 = 0;
  localparam int M01 = 1;
  localparam int M02 = 2;
  localparam int M10 = 3;
  localparam int M11 = 4;
  localparam int M12 = 5;
  localparam int M20 = 6;
  localparam int M21 = 7;
  localparam int M22 = 8;

  // Concatenation lists element 8 first so element 0 lands in the LSBs.
  localparam logic [9*32-1:0] IDENTITY_MATRIX_FLAT = {
    Q_ONE, 32'h0, 32'h0,
    32'h0, Q_ONE, 32'h0,
    32'h0, 32'h0, Q_ONE
  };

endpackage
`default_nettype wire

// File: rtl/color_matrix_apply_if.sv
`default_nettype none
// ============================================================================
//  Module   : color_matrix_apply_if
//  Purpose  : Bundles the matrix-update channel and the RGB pixel stream
//             (valid/ready) of color_matrix_apply.
//  Ports    : comp_matrix_flat/matrix_valid/matrix_pending - matrix channel
//             pix_in/pix_sof_in/pix_valid_in/pix_ready_out - input stream
//             pix_out/pix_sof_out/pix_valid_out/pix_ready_in - output stream
//             modport slave  : the colour-matrix block
//             modport master : the environment driving it
//  Revision : 1.0 - initial release
// ============================================================================
interface color_matrix_apply_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 32
);
  logic [9*COEF_W-1:0] comp_matrix_flat;
  logic                matrix_valid;
  logic                matrix_pending;
  logic [3*DATA_W-1:0] pix_in;
  logic                pix_sof_in;
  logic                pix_valid_in;
  logic                pix_ready_out;
  logic [3*DATA_W-1:0] pix_out;
  logic                pix_sof_out;
  logic                pix_valid_out;
  logic                pix_ready_in;

  modport slave (
    input  comp_matrix_flat, matrix_valid, pix_in, pix_sof_in,
           pix_valid_in, pix_ready_in,
    output matrix_pending, pix_ready_out, pix_out, pix_sof_out, pix_valid_out
  );

  modport master (
    output comp_matrix_flat, matrix_valid, pix_in, pix_sof_in,
           pix_valid_in, pix_ready_in,
    input  matrix_pending, pix_ready_out, pix_out, pix_sof_out, pix_valid_out
  );
endinterface
`default_nettype wire

// File: rtl/color_matrix_apply_row_mac.sv
`default_nettype none
// ============================================================================
//  Module   : cma_row_mac
//  Purpose  : One output channel of the colour matrix: three signed products
//             (S1), their sum (S2), then round-half-up, shift and clamp to
//             the unsigned channel range (S3). All stages share one enable.
//  Ports    : clk, rst_n     - clock, async active-low reset
//             i_en           - pipeline advance enable
//             i_coef0..2     - signed Q coefficients of this matrix row
//             i_ch0..2       - unsigned R, G, B channel values
//             o_ch           - registered, clamped channel result
//  Revision : 1.0 - initial release
// ============================================================================
module cma_row_mac #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [COEF_W-1:0] i_coef0,
  input  logic [COEF_W-1:0] i_coef1,
  input  logic [COEF_W-1:0] i_coef2,
  input  logic [DATA_W-1:0] i_ch0,
  input  logic [DATA_W-1:0] i_ch1,
  input  logic [DATA_W-1:0] i_ch2,
  output logic [DATA_W-1:0] o_ch
);
  localparam int P_W = COEF_W + DATA_W + 1;
  localparam int S_W = P_W + 2;
  localparam logic signed [S_W-1:0] c_RND =
    {{(S_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  // Coefficient sign-extended, channel zero-extended, both to product width.
  function automatic logic signed [P_W-1:0] f_mul(input logic [COEF_W-1:0] c,
                                                  input logic [DATA_W-1:0] x);
    logic signed [P_W-1:0] a;
    logic signed [P_W-1:0] b;
    a = $signed({{(P_W-COEF_W){c[COEF_W-1]}}, c});
    b = $signed({{(P_W-DATA_W){1'b0}}, x});
    return a * b;
  endfunction

  function automatic logic signed [S_W-1:0] f_sx(input logic signed [P_W-1:0] p);
    return $signed({{(S_W-P_W){p[P_W-1]}}, p});
  endfunction

  logic signed [P_W-1:0] r_p0, r_p1, r_p2;
  logic signed [S_W-1:0] r_sum;
  logic signed [S_W-1:0] w_rnd;
  logic signed [S_W-1:0] w_shr;
  logic [DATA_W-1:0]     w_clamp;

  assign w_rnd = r_sum + c_RND;
  assign w_shr = w_rnd >>> FRAC_BITS;

  always_comb begin
    w_clamp = w_shr[DATA_W-1:0];
    if (w_shr[S_W-1]) begin
      w_clamp = '0;
    end else if (|w_shr[S_W-2:DATA_W]) begin
      w_clamp = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0  <= '0;
      r_p1  <= '0;
      r_p2  <= '0;
      r_sum <= '0;
      o_ch  <= '0;
    end else if (i_en) begin
      r_p0  <= f_mul(i_coef0, i_ch0);
      r_p1  <= f_mul(i_coef1, i_ch1);
      r_p2  <= f_mul(i_coef2, i_ch2);
      r_sum <= f_sx(r_p0) + f_sx(r_p1) + f_sx(r_p2);
      o_ch  <= w_clamp;
    end
  end
endmodule
`default_nettype wire

// File: rtl/color_matrix_apply.sv
`default_nettype none
// ============================================================================
//  Module   : color_matrix_apply
//  Purpose  : Applies a 3x3 Q16.16 colour matrix to an RGB888 stream. New
//             matrices are held pending and committed only on an accepted
//             start-of-frame beat, so each frame uses a single matrix.
//  Ports    : clk, rst_n - clock, async active-low reset
//             bus        - color_matrix_apply_if.slave (matrix channel and
//                          valid/ready pixel in/out streams)
//  Revision : 1.0 - initial release
// ============================================================================
module color_matrix_apply #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  color_matrix_apply_if.slave  bus
);
  import cam_pkg::*;

  logic [9*COEF_W-1:0] r_active;
  logic [9*COEF_W-1:0] r_pending;
  logic                r_pending_flag;
  logic [2:0]          r_vld;
  logic [2:0]          r_sof;

  logic                w_en;
  logic                w_accept;
  logic                w_commit;
  logic [9*COEF_W-1:0] w_mat;
  logic [DATA_W-1:0]   w_ch [3];

  // Whole pipeline advances whenever the output slot is empty or drained.
  assign w_en     = !r_vld[2] | bus.pix_ready_in;
  assign w_accept = bus.pix_valid_in & w_en;
  assign w_commit = w_accept & bus.pix_sof_in & r_pending_flag;
  // The committing SOF beat already sees the new matrix in stage 1.
  assign w_mat    = w_commit ? r_pending : r_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active       <= IDENTITY_MATRIX_FLAT;
      r_pending      <= IDENTITY_MATRIX_FLAT;
      r_pending_flag <= 1'b0;
    end else begin
      // A strobe coinciding with a commit refills pending and keeps the flag.
      if (bus.matrix_valid) begin
        r_pending      <= bus.comp_matrix_flat;
        r_pending_flag <= 1'b1;
      end else if (w_commit) begin
        r_pending_flag <= 1'b0;
      end
      if (w_commit) begin
        r_active <= r_pending;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_sof <= '0;
    end else if (w_en) begin
      r_vld <= {r_vld[1:0], w_accept};
      r_sof <= {r_sof[1:0], w_accept & bus.pix_sof_in};
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    cma_row_mac #(
      .DATA_W    (DATA_W),
      .COEF_W    (COEF_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_en),
      .i_coef0 (w_mat[(M00 + 3*r + 0)*COEF_W +: COEF_W]),
      .i_coef1 (w_mat[(M00 + 3*r + 1)*COEF_W +: COEF_W]),
      .i_coef2 (w_mat[(M00 + 3*r + 2)*COEF_W +: COEF_W]),
      .i_ch0   (bus.pix_in[2*DATA_W +: DATA_W]),
      .i_ch1   (bus.pix_in[DATA_W +: DATA_W]),
      .i_ch2   (bus.pix_in[0 +: DATA_W]),
      .o_ch    (w_ch[r])
    );
  end

  assign bus.pix_out        = {w_ch[0], w_ch[1], w_ch[2]};
  assign bus.pix_sof_out    = r_sof[2];
  assign bus.pix_valid_out  = r_vld[2];
  assign bus.pix_ready_out  = w_en;
  assign bus.matrix_pending = r_pending_flag;
endmodule
`default_nettype wire

// File: doc/color_matrix_apply.md
Name: color_matrix_apply

Overview:
Consumer end of the compensation-matrix interface produced by bradford_chromatic_adapt. The block captures each new 3x3 Q16.16 matrix when matrix_valid is asserted. It applies the matrix to a streaming RGB888 pixel channel that has valid/ready flow control. A new matrix takes effect only at a frame boundary, so a frame is never processed with two different matrices. The block sits between the pixel source and the display output path.

Parameters:
DATA_W, 8, bits per colour channel (unsigned).
COEF_W, 32, coefficient width (signed, two's complement).
FRAC_BITS, 16, fractional bits of the coefficients (Q16.16).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
comp_matrix_flat  in  9*COEF_W  row-major matrix; element i occupies bits [i*COEF_W +: COEF_W]; element 0 = M[0][0], element 8 = M[2][2]
matrix_valid  in  1  one-cycle strobe; comp_matrix_flat is valid in this cycle
matrix_pending  out  1  a captured matrix is waiting for the next start-of-frame (SOF)
pix_in  in  3*DATA_W  {R,G,B}; R occupies the MSBs
pix_sof_in  in  1  marks the first pixel of a frame
pix_valid_in  in  1  input beat valid
pix_ready_out  out  1  block can accept an input beat
pix_out  out  3*DATA_W  corrected {R,G,B}
pix_sof_out  out  1  SOF aligned with pix_out
pix_valid_out  out  1  output beat valid
pix_ready_in  in  1  downstream ready

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low via rst_n.
- Reset values:
  - all pix_*_out signals = 0; pix_ready_out = 1 (it is combinational from the pipeline state); matrix_pending = 0.
  - Active and pending matrices = identity: diagonal elements 0x00010000, all others 0.
  - All pipeline valid bits = 0.
- Matrix capture:
  - On matrix_valid, copy comp_matrix_flat into the pending register and set matrix_pending.
  - A later matrix_valid before the next SOF overwrites the pending register; last one wins.
- Matrix commit:
  - Commit happens on an accepted beat (pix_valid_in & pix_ready_out) that carries pix_sof_in = 1 while matrix_pending = 1.
  - On commit: active <= pending, clear matrix_pending. That SOF pixel and every later pixel use the new matrix.
  - Pixels already inside the pipeline keep the matrix they were issued with. Each stage-1 product uses the active matrix value seen by that beat.
- Simultaneous matrix_valid and commit beat:
  - The commit uses the pending contents from before this cycle.
  - The new matrix is written to pending, and matrix_pending stays 1.
- Datapath, 3 stages, latency 3 cycles with no stall:
  - S1: nine signed products, M[r][c] times the zero-extended channel value. Products are COEF_W+DATA_W+1 bits.
  - S2: three row sums, each 2 bits wider than a product. No overflow is possible.
  - S3: add 2^(FRAC_BITS-1) (round half up), arithmetic shift right by FRAC_BITS, then clamp: a negative result gives 0; a result above 2^DATA_W-1 gives 2^DATA_W-1.
  - pix_sof_out travels alongside the data through all three stages.
- Flow control:
  - Global stall enable en = !pix_valid_out | pix_ready_in. All stages advance only when en = 1.
  - pix_ready_out = en. Throughput is 1 pixel/cycle when the sink is always ready.
  - pix_out and pix_valid_out hold steady while stalled.
  - No beat is lost or duplicated. Pipeline bubbles travel as valid = 0 entries.
- matrix_valid is honoured even while the pipeline is stalled. Matrix commit happens only on an accepted SOF beat.
- An SOF beat with matrix_pending = 0 passes through with no change to the matrix.
- Reset mid-operation immediately flushes all pipeline contents and restores the identity matrix.

Decomposition:
- Shared package cam_pkg:
  - Q16.16 constants: Q_ONE = 32'h0001_0000, Q_HALF = 32'h0000_8000.
  - IDENTITY_MATRIX_FLAT.
  - Element index constants M00..M22.
- One sub-module: cma_row_mac. It computes one output channel (3 products, sum, round/clamp) with the shared stall enable, and is instantiated three times.

Test Plan:
- Identity after reset: pix_in = (100,150,200) with SOF -> pix_out = (100,150,200) exactly 3 cycles later; pix_sof_out = 1.
- Deferred commit: matrix_valid with diagonal 0x00020000, then a non-SOF pixel (100,50,10) -> (100,50,10) and matrix_pending = 1. Next SOF pixel (100,50,10) -> (200,100,20); matrix_pending then 0.
- Saturation/clamp: diagonal 2.0 committed, pixel (200,0,0) -> (255,0,0). Matrix with M00 = 0xFFFF0000 (-1.0) committed, pixel (50,0,0) -> (0,0,0).
- Rounding: diagonal 0x00008000 (0.5) committed, pixel (3,4,5) -> (2,2,3).
- Backpressure: stream pixels 1..20, hold pix_ready_in low for 5 cycles mid-stream -> output is exactly 1..20 in order, pix_out stays stable during the stall, and pix_ready_out = 0 while the output is full.
- Collision and reset: matrix_valid (matrix B) in the same cycle as an SOF commit of pending matrix A -> that frame uses A and matrix_pending = 1. Then assert rst_n low mid-frame -> all outputs 0, and the next pixel is processed with the identity matrix.
